// File: rtl/f2_sweep_ctrl.sv
// F2 frequency-adjust sequencer: manual Plus/Minus stepping from debounced buttons or an
// automatic dwell-timed triangle sweep. Define F2_SWEEP_ONESHOT_EN for a single upward ramp.
module f2_sweep_ctrl #(
  parameter int SCALE_W   = 6,
  parameter int SCALE_MIN = 0,
  parameter int SCALE_MAX = 63,
  parameter int DWELL_CYC = 12500000,
  parameter int CNT_W     = 24
) (
  input  logic               sysclk,
  input  logic               rst_n,
  input  logic               Enable_F2,
  input  logic               Bt_Plus,
  input  logic               Bt_Minus,
  input  logic               Bt_Mode,
  output logic               Plus,
  output logic               Minus,
  output logic [SCALE_W-1:0] Scale_Track,
  output logic               Sweep_Active,
  output logic               Sweep_Dir
);

  typedef enum logic [1:0] {MANUAL, SWEEP_DWELL, SWEEP_STEP} state_t;

  localparam logic [SCALE_W-1:0] S_MIN      = SCALE_W'(SCALE_MIN);
  localparam logic [SCALE_W-1:0] S_MAX      = SCALE_W'(SCALE_MAX);
  localparam logic [CNT_W-1:0]   DWELL_LAST = CNT_W'(DWELL_CYC - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   timer, timer_nxt;
  logic [SCALE_W-1:0] scale_nxt;
  logic               dir_nxt, plus_nxt, minus_nxt, step_up;
  logic               prev_plus, prev_minus, prev_mode;
  logic               e_plus, e_minus, e_mode, abort;

  assign e_plus  = Bt_Plus  & ~prev_plus;
  assign e_minus = Bt_Minus & ~prev_minus;
  assign e_mode  = Bt_Mode  & ~prev_mode;
  assign abort   = e_plus | e_minus | e_mode;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    scale_nxt = Scale_Track;
    dir_nxt   = Sweep_Dir;
    plus_nxt  = 1'b0;
    minus_nxt = 1'b0;
    step_up   = Sweep_Dir;
    if (!Enable_F2) begin
      state_nxt = MANUAL;
      timer_nxt = '0;
    end else begin
      case (state)
        MANUAL: begin
          if (e_mode) begin
            state_nxt = SWEEP_DWELL;
            timer_nxt = '0;
            dir_nxt   = 1'b1;
          end else if (e_plus && !e_minus) begin
            if (Scale_Track < S_MAX) begin
              plus_nxt  = 1'b1;
              scale_nxt = Scale_Track + 1'b1;
            end
          end else if (e_minus && !e_plus) begin
            if (Scale_Track > S_MIN) begin
              minus_nxt = 1'b1;
              scale_nxt = Scale_Track - 1'b1;
            end
          end
        end
        SWEEP_DWELL: begin
          if (abort) begin
            state_nxt = MANUAL;
            timer_nxt = '0;
          end else if (timer == DWELL_LAST) begin
            state_nxt = SWEEP_STEP;
            timer_nxt = '0;
          end else begin
            timer_nxt = timer + CNT_W'(1);
          end
        end
        SWEEP_STEP: begin
          timer_nxt = '0;
          if (abort) begin
            state_nxt = MANUAL;
          end else begin
            // reverse at the limits so the turn-around value is not repeated
            if (Sweep_Dir && Scale_Track == S_MAX)
              step_up = 1'b0;
            else if (!Sweep_Dir && Scale_Track == S_MIN)
              step_up = 1'b1;
`ifdef F2_SWEEP_ONESHOT_EN
            if (Sweep_Dir && Scale_Track == S_MAX) begin
              state_nxt = MANUAL;
            end else begin
              state_nxt = SWEEP_DWELL;
              dir_nxt   = step_up;
              if (step_up) begin
                plus_nxt  = 1'b1;
                scale_nxt = Scale_Track + 1'b1;
              end else begin
                minus_nxt = 1'b1;
                scale_nxt = Scale_Track - 1'b1;
              end
            end
`else
            state_nxt = SWEEP_DWELL;
            dir_nxt   = step_up;
            if (step_up) begin
              plus_nxt  = 1'b1;
              scale_nxt = Scale_Track + 1'b1;
            end else begin
              minus_nxt = 1'b1;
              scale_nxt = Scale_Track - 1'b1;
            end
`endif
          end
        end
        default: begin
          state_nxt = MANUAL;
          timer_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state        <= MANUAL;
      timer        <= '0;
      Plus         <= 1'b0;
      Minus        <= 1'b0;
      Scale_Track  <= S_MIN;
      Sweep_Dir    <= 1'b1;
      Sweep_Active <= 1'b0;
      prev_plus    <= 1'b0;
      prev_minus   <= 1'b0;
      prev_mode    <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      Plus         <= plus_nxt;
      Minus        <= minus_nxt;
      Scale_Track  <= scale_nxt;
      Sweep_Dir    <= dir_nxt;
      Sweep_Active <= (state_nxt != MANUAL);
      // level history keeps tracking while disabled so a held button is not a fresh press
      prev_plus    <= Bt_Plus;
      prev_minus   <= Bt_Minus;
      prev_mode    <= Bt_Mode;
    end
  end

endmodule
